ahb_sub_mem_bridge: RTL and testbench
=====================================

AHB_SUB_MEM_BRIDGE -- requirements
Module: ahb_sub_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus/memory data width, one of 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter MEM_BASE, default 0, first byte address decoded.
REQ-004 SHALL have parameter MEM_SIZE, default 4096, decoded window in bytes, power of two.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum data-phase wait cycles.
REQ-006 SHALL have ports, one clock and one asynchronous active-low reset:
- clk  in  1  clock.
- nReset  in  1  asynchronous active-low reset.
- sel  in  1  subordinate select.
- readyIn  in  1  bus ready.
- trans  in  2  AHBCommon_pkg transfer type.
- burst  in  3  AHBCommon_pkg burst type.
- size  in  3  transfer size, log2 bytes.
- write  in  1  1 = write.
- addr  in  ADDR_W  address.
- wData  in  DATA_W  write data.
- readyOut  out  1  transfer done.
- resp  out  1  OKAY/ERROR.
- rData  out  DATA_W  read data.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is write.
- mem_addr  out  ADDR_W  word-aligned memory-relative address.
- mem_strb  out  DATA_W/8  byte enables.
- mem_wData  out  DATA_W  write data.
- mem_ready  in  1  memory completes access this cycle.
- mem_rData  in  DATA_W  read data, valid with mem_ready.
- mem_err  in  1  memory error, valid with mem_ready.

Function
REQ-007 SHALL accept an address phase when sel && readyIn && trans is NONSEQ or SEQ; IDLE and BUSY receive a zero-wait OKAY with no memory access.
REQ-008 SHALL use FSM states IDLE, ACCESS, ERR1 and ERR2; accepted valid phase -> ACCESS; accepted invalid phase -> ERR1; ERR1 -> ERR2 -> IDLE, or ACCESS/ERR1 if a new phase is accepted in ERR2.
REQ-009 SHALL flag an accepted phase invalid if: addr is outside [MEM_BASE, MEM_BASE+MEM_SIZE); addr is not 2^size aligned; 2^size > DATA_W/8; or a SEQ addr != expected next address.
REQ-010 SHALL compute the expected SEQ address from the previous beat: INCR/INCRx -> prev+2^size; WRAPx -> prev+2^size wrapped within an aligned (beats*2^size) block; SINGLE followed by SEQ -> invalid.
REQ-011 In ACCESS, SHALL hold mem_req=1 with mem_write, mem_addr and mem_strb registered from the address phase, and mem_wData=wData combinationally, until mem_ready=1.
REQ-012 SHALL set mem_strb = ((1<<2^size)-1) << addr[log2(DATA_W/8)-1:0].
REQ-013 In ACCESS, SHALL drive readyOut=mem_ready, with rData=mem_rData when readyOut=1; zero wait states are possible.
REQ-014 mem_ready with mem_err=1 SHALL be converted to the two-cycle error (ERR1 with readyOut=0, ERR2 with readyOut=1) instead of completing OKAY.
REQ-015 Both error cycles SHALL drive resp=ERROR; all other cycles SHALL drive resp=OKAY; invalid phases never assert mem_req.
REQ-016 A data phase in progress SHALL complete even if sel drops; a new phase accepted on the completing cycle SHALL start with no bubble.
REQ-017 rData SHALL be 0 when readyOut=0 or the transfer is a write.

Reset
REQ-018 On nReset=0, asynchronously: state=IDLE, readyOut=1, resp=OKAY, mem_req=0, mem_strb=0, rData=0, and the burst tracking register cleared.
REQ-019 Reset mid-ACCESS SHALL drop mem_req in the same cycle and discard the transfer.

Configuration
REQ-020 With AHB_SUB_MEM_TIMEOUT_EN defined, a counter SHALL abort ACCESS after TIMEOUT cycles without mem_ready: drop mem_req and enter ERR1.
REQ-021 Without AHB_SUB_MEM_TIMEOUT_EN, no counter SHALL exist and ACCESS waits indefinitely.

Structure
REQ-022 Trans, burst, resp and size encodings plus the new state enum SHALL live in AHBCommon_pkg.
REQ-023 Range, alignment and SEQ-address checks SHALL be a combinational sub-module ahb_sub_mem_addr_chk.

Verification
REQ-024 Write NONSEQ addr=MEM_BASE+0x4, size=2, wData=0xDEADBEEF, mem_ready at the second ACCESS cycle -> mem_strb=0xF, one wait state, resp=OKAY.
REQ-025 Read with size=0 at addr=MEM_BASE+0x3 and zero wait -> mem_strb=0x8 (DATA_W=32), readyOut=1 in the first data cycle.
REQ-026 Unaligned addr=MEM_BASE+0x2 with size=2 -> no mem_req, readyOut 0 then 1 with resp=ERROR on both cycles.
REQ-027 WRAP4, size=2, start addr=0x0C -> expected addresses 0x00, 0x04, 0x08 accepted; SEQ 0x10 -> ERROR.
REQ-028 AHB_SUB_MEM_TIMEOUT_EN defined, TIMEOUT=16, mem_ready held 0 -> mem_req drops after 16 cycles, two-cycle ERROR follows.
REQ-029 nReset pulsed during ACCESS -> mem_req=0 and readyOut=1 immediately; the next transfer completes normally.

Source files
------------

// File: rtl/AHBCommon_pkg.sv
// Shared AHB encodings and the memory-bridge state enum.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package AHBCommon_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_128   = 3'd4,
        HSIZE_256   = 3'd5,
        HSIZE_512   = 3'd6,
        HSIZE_1024  = 3'd7
    } hsize_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } sub_mem_state_t;

    // Control half of the burst tracking register (the address is kept
    // separately because its width is a module parameter).
    typedef struct packed {
        logic    vld;
        hburst_t burst;
        hsize_t  size;
    } beat_ctl_t;

    function automatic logic is_wrap(input hburst_t b);
        return (b == HBURST_WRAP4) || (b == HBURST_WRAP8) || (b == HBURST_WRAP16);
    endfunction

    // Beat count of a wrapping burst; 0 for everything else.
    function automatic logic [4:0] wrap_beats(input hburst_t b);
        case (b)
            HBURST_WRAP4:  return 5'd4;
            HBURST_WRAP8:  return 5'd8;
            HBURST_WRAP16: return 5'd16;
            default:       return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sub_mem_addr_chk.sv
// Address-phase legality check: window range, size alignment, size vs bus width, SEQ continuity.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports: trans/size/addr of the current address phase, prev_addr/prev of the
// last accepted beat, phase_ok = 1 when the phase may go to memory.
module ahb_sub_mem_addr_chk
    import AHBCommon_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE = '0,
    parameter int                MEM_SIZE = 4096
) (
    input  logic [1:0]        trans,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] prev_addr,
    input  beat_ctl_t         prev,
    output logic              phase_ok
);

    localparam int                LANE_W = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] SIZE_L = ADDR_W'(MEM_SIZE);

    logic [ADDR_W:0]   diff;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] prev_step;
    logic [ADDR_W-1:0] incr_next;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] exp_addr;
    logic              in_range;
    logic              aligned;
    logic              size_ok;
    logic              seq_ok;

    always_comb begin
        // Extra MSB acts as a borrow: set when addr is below the window.
        diff      = {1'b0, addr} - {1'b0, MEM_BASE};
        in_range  = !diff[ADDR_W] && (diff[ADDR_W-1:0] < SIZE_L);

        step      = ADDR_W'(1) << size;
        aligned   = (addr & (step - ADDR_W'(1))) == '0;
        size_ok   = int'(size) <= LANE_W;

        prev_step = ADDR_W'(1) << prev.size;
        incr_next = prev_addr + prev_step;
        wrap_mask = (ADDR_W'(wrap_beats(prev.burst)) << prev.size) - ADDR_W'(1);
        exp_addr  = is_wrap(prev.burst) ? ((prev_addr & ~wrap_mask) | (incr_next & wrap_mask))
                                         : incr_next;

        // A SINGLE has no successor, so any SEQ after it is illegal.
        seq_ok    = (trans != HTRANS_SEQ) ||
                    (prev.vld && (prev.burst != HBURST_SINGLE) && (addr == exp_addr));

        phase_ok  = in_range && aligned && size_ok && seq_ok;
    end

endmodule

// File: rtl/ahb_sub_mem_bridge.sv
// AHB subordinate to simple req/ready memory bridge with two-cycle ERROR responses.
// Latency: data phase completes in the cycle mem_ready is seen (zero-wait possible).
// Backpressure: readyOut follows mem_ready in ACCESS; ACCESS waits indefinitely unless
//               AHB_SUB_MEM_TIMEOUT_EN is defined, which aborts after TIMEOUT cycles.
//
// Ports: clk/nReset; AHB side sel, readyIn, trans, burst, size, write, addr, wData,
// readyOut, resp, rData; memory side mem_req, mem_write, mem_addr (window relative,
// word aligned), mem_strb, mem_wData, mem_ready, mem_rData, mem_err.
module ahb_sub_mem_bridge
    import AHBCommon_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE = '0,
    parameter int                MEM_SIZE = 4096,
    parameter int                TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  sel,
    input  logic                  readyIn,
    input  logic [1:0]            trans,
    input  logic [2:0]            burst,
    input  logic [2:0]            size,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wData,
    output logic                  readyOut,
    output logic                  resp,
    output logic [DATA_W-1:0]     rData,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_strb,
    output logic [DATA_W-1:0]     mem_wData,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rData,
    input  logic                  mem_err
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam int                LANE_W    = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(STRB_W - 1);

    sub_mem_state_t    state_q, state_d, accept_state;
    logic              ready_int;
    logic              accept;
    logic              phase_ok;
    logic              abort;

    logic              wr_q;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [ADDR_W-1:0] trk_addr_q;
    beat_ctl_t         trk_q;

    ahb_sub_mem_addr_chk #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_chk (
        .trans     (trans),
        .size      (size),
        .addr      (addr),
        .prev_addr (trk_addr_q),
        .prev      (trk_q),
        .phase_ok  (phase_ok)
    );

    // Our own readyOut is what the bus sees as HREADY while we own the data
    // phase; gating on it keeps a stalled beat from being overwritten.
    always_comb begin
        ready_int = 1'b1;
        case (state_q)
            ST_ACCESS: ready_int = mem_ready && !mem_err;
            ST_ERR1:   ready_int = 1'b0;
            default:   ready_int = 1'b1;
        endcase
    end

    assign accept       = sel && readyIn && ready_int &&
                          ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    assign accept_state = phase_ok ? ST_ACCESS : ST_ERR1;

`ifdef AHB_SUB_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Restarts on every completion so back-to-back beats each get a full budget.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)                                 to_cnt_q <= '0;
        else if ((state_q == ST_ACCESS) && !mem_ready) to_cnt_q <= to_cnt_q + TO_W'(1);
        else                                         to_cnt_q <= '0;
    end

    assign abort = (state_q == ST_ACCESS) && !mem_ready && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = accept_state;
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    if (mem_err)     state_d = ST_ERR1;
                    else if (accept) state_d = accept_state;
                    else             state_d = ST_IDLE;
                end else if (abort) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = accept ? accept_state : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Byte lanes covered by the beat, starting at the lane addr points into.
    always_comb begin
        int lane;
        int nbytes;
        lane    = int'(addr[LANE_W-1:0]);
        nbytes  = 1 << size;
        strb_d  = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_d[i] = (i >= lane) && (i < lane + nbytes);
        end
        maddr_d = (addr - MEM_BASE) & ~LANE_MASK;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_q       <= 1'b0;
            maddr_q    <= '0;
            strb_q     <= '0;
            trk_addr_q <= '0;
            trk_q      <= '0;
        end else if (accept) begin
            wr_q       <= write;
            maddr_q    <= maddr_d;
            strb_q     <= strb_d;
            trk_addr_q <= addr;
            trk_q      <= '{vld: 1'b1, burst: hburst_t'(burst), size: hsize_t'(size)};
        end
    end

    assign readyOut  = ready_int;
    assign resp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_write = (state_q == ST_ACCESS) && wr_q;
    assign mem_addr  = maddr_q;
    assign mem_strb  = (state_q == ST_ACCESS) ? strb_q : '0;
    assign mem_wData = wData;
    assign rData     = ((state_q == ST_ACCESS) && ready_int && !wr_q) ? mem_rData : '0;

endmodule

// File: tb/tb_ahb_sub_mem_bridge.sv
module tb_ahb_sub_mem_bridge;
    import AHBCommon_pkg::*;

    logic        clk = 1'b0;
    logic        nReset;
    logic        sel;
    logic        readyIn;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wData;
    logic        readyOut;
    logic        resp;
    logic [31:0] rData;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wData;
    logic        mem_ready;
    logic [31:0] mem_rData;
    logic        mem_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ahb_sub_mem_bridge #(
        .DATA_W(32), .ADDR_W(32), .MEM_BASE(32'h0), .MEM_SIZE(4096), .TIMEOUT(16)
    ) dut (
        .clk(clk), .nReset(nReset), .sel(sel), .readyIn(readyIn), .trans(trans),
        .burst(burst), .size(size), .write(write), .addr(addr), .wData(wData),
        .readyOut(readyOut), .resp(resp), .rData(rData), .mem_req(mem_req),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_strb(mem_strb),
        .mem_wData(mem_wData), .mem_ready(mem_ready), .mem_rData(mem_rData),
        .mem_err(mem_err)
    );

    task automatic addr_ph(input logic [1:0] tr, input logic [2:0] bu,
                           input logic [2:0] sz, input logic wr, input logic [31:0] a);
        sel = 1'b1; readyIn = 1'b1; trans = tr; burst = bu; size = sz; write = wr; addr = a;
    endtask

    task automatic bus_idle();
        sel = 1'b0; readyIn = 1'b1; trans = HTRANS_IDLE; burst = HBURST_SINGLE;
        size = 3'd0; write = 1'b0; addr = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL rst_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (resp !== 1'b0) $display("FAIL rst_resp got=%0h exp=0", resp); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0h exp=0", mem_req); else pass_cnt++;
        total_cnt++; if (mem_strb !== 4'h0) $display("FAIL rst_strb got=%0h exp=0", mem_strb); else pass_cnt++;
        total_cnt++; if (rData !== 32'h0) $display("FAIL rst_rdata got=%0h exp=0", rData); else pass_cnt++;
        next_cycle();
        nReset = 1'b1;
        next_cycle();
    endtask

    task automatic test_write_wait();
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b1, 32'h4);
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL wr_addr_ready got=%0h exp=1", readyOut); else pass_cnt++;
        next_cycle();
        bus_idle(); wData = 32'hDEADBEEF; mem_rData = 32'h12345678; mem_ready = 1'b0;
        @(negedge clk);
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL wr_req got=%0h exp=1", mem_req); else pass_cnt++;
        total_cnt++; if (mem_write !== 1'b1) $display("FAIL wr_write got=%0h exp=1", mem_write); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h4) $display("FAIL wr_addr got=%0h exp=4", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_strb !== 4'hF) $display("FAIL wr_strb got=%0h exp=f", mem_strb); else pass_cnt++;
        total_cnt++; if (mem_wData !== 32'hDEADBEEF) $display("FAIL wr_wdata got=%0h exp=deadbeef", mem_wData); else pass_cnt++;
        total_cnt++; if (readyOut !== 1'b0) $display("FAIL wr_wait_ready got=%0h exp=0", readyOut); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL wr_done_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (resp !== 1'b0) $display("FAIL wr_done_resp got=%0h exp=0", resp); else pass_cnt++;
        total_cnt++; if (rData !== 32'h0) $display("FAIL wr_rdata_zero got=%0h exp=0", rData); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL wr_after_req got=%0h exp=0", mem_req); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_read_byte();
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd0, 1'b0, 32'h3);
        next_cycle();
        bus_idle(); mem_ready = 1'b1; mem_rData = 32'hA1B2C3D4;
        @(negedge clk);
        total_cnt++; if (mem_strb !== 4'h8) $display("FAIL rd_strb got=%0h exp=8", mem_strb); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0) $display("FAIL rd_addr got=%0h exp=0", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_write !== 1'b0) $display("FAIL rd_write got=%0h exp=0", mem_write); else pass_cnt++;
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL rd_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (rData !== 32'hA1B2C3D4) $display("FAIL rd_rdata got=%0h exp=a1b2c3d4", rData); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
    endtask

    // Unaligned, out of window, and wider than the bus: all must give the
    // two-cycle ERROR without touching memory.
    task automatic test_invalid_phase();
        logic [31:0] va [3];
        logic [2:0]  vs [3];
        va = '{32'h2, 32'h1000, 32'h8};
        vs = '{3'd2, 3'd2, 3'd3};
        for (int i = 0; i < 3; i++) begin
            addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, vs[i], 1'b0, va[i]);
            next_cycle();
            bus_idle();
            @(negedge clk);
            total_cnt++; if (mem_req !== 1'b0) $display("FAIL inv%0d_e1_req got=%0h exp=0", i, mem_req); else pass_cnt++;
            total_cnt++; if (readyOut !== 1'b0) $display("FAIL inv%0d_e1_ready got=%0h exp=0", i, readyOut); else pass_cnt++;
            total_cnt++; if (resp !== 1'b1) $display("FAIL inv%0d_e1_resp got=%0h exp=1", i, resp); else pass_cnt++;
            next_cycle();
            @(negedge clk);
            total_cnt++; if (mem_req !== 1'b0) $display("FAIL inv%0d_e2_req got=%0h exp=0", i, mem_req); else pass_cnt++;
            total_cnt++; if (readyOut !== 1'b1) $display("FAIL inv%0d_e2_ready got=%0h exp=1", i, readyOut); else pass_cnt++;
            total_cnt++; if (resp !== 1'b1) $display("FAIL inv%0d_e2_resp got=%0h exp=1", i, resp); else pass_cnt++;
            next_cycle();
        end
        @(negedge clk);
        total_cnt++; if (resp !== 1'b0) $display("FAIL inv_idle_resp got=%0h exp=0", resp); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_mem_err();
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b0, 32'h20);
        next_cycle();
        bus_idle(); mem_ready = 1'b1; mem_err = 1'b1; mem_rData = 32'h55;
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b0) $display("FAIL merr_ready got=%0h exp=0", readyOut); else pass_cnt++;
        total_cnt++; if (rData !== 32'h0) $display("FAIL merr_rdata got=%0h exp=0", rData); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0; mem_err = 1'b0;
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b0) $display("FAIL merr_e1_ready got=%0h exp=0", readyOut); else pass_cnt++;
        total_cnt++; if (resp !== 1'b1) $display("FAIL merr_e1_resp got=%0h exp=1", resp); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL merr_e1_req got=%0h exp=0", mem_req); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL merr_e2_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (resp !== 1'b1) $display("FAIL merr_e2_resp got=%0h exp=1", resp); else pass_cnt++;
        next_cycle();
    endtask

    // WRAP4 from 0x0C: 0x0C, 0x00, 0x04, 0x08 back to back, then 0x10 breaks the wrap.
    task automatic test_back_to_back_wrap();
        logic [31:0] cur [4];
        logic [31:0] nxt [4];
        cur = '{32'hC, 32'h0, 32'h4, 32'h8};
        nxt = '{32'h0, 32'h4, 32'h8, 32'h10};
        mem_ready = 1'b1;
        addr_ph(HTRANS_NONSEQ, HBURST_WRAP4, 3'd2, 1'b1, 32'hC);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            addr_ph(HTRANS_SEQ, HBURST_WRAP4, 3'd2, 1'b1, nxt[i]);
            @(negedge clk);
            total_cnt++; if (mem_req !== 1'b1) $display("FAIL wrap%0d_req got=%0h exp=1", i, mem_req); else pass_cnt++;
            total_cnt++; if (mem_addr !== cur[i]) $display("FAIL wrap%0d_addr got=%0h exp=%0h", i, mem_addr, cur[i]); else pass_cnt++;
            total_cnt++; if (readyOut !== 1'b1) $display("FAIL wrap%0d_ready got=%0h exp=1", i, readyOut); else pass_cnt++;
            next_cycle();
        end
        bus_idle();
        @(negedge clk);
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL wrap_err_req got=%0h exp=0", mem_req); else pass_cnt++;
        total_cnt++; if (resp !== 1'b1) $display("FAIL wrap_err_resp got=%0h exp=1", resp); else pass_cnt++;
        total_cnt++; if (readyOut !== 1'b0) $display("FAIL wrap_err_ready got=%0h exp=0", readyOut); else pass_cnt++;
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
    endtask

    // INCR with a skipped beat, then a new phase taken in ERR2: SINGLE followed by SEQ.
    task automatic test_incr_single();
        mem_ready = 1'b1;
        addr_ph(HTRANS_NONSEQ, HBURST_INCR, 3'd2, 1'b0, 32'h40);
        next_cycle();
        addr_ph(HTRANS_SEQ, HBURST_INCR, 3'd2, 1'b0, 32'h44);
        @(negedge clk);
        total_cnt++; if (mem_addr !== 32'h40) $display("FAIL incr0_addr got=%0h exp=40", mem_addr); else pass_cnt++;
        next_cycle();
        addr_ph(HTRANS_SEQ, HBURST_INCR, 3'd2, 1'b0, 32'h4C);
        @(negedge clk);
        total_cnt++; if (mem_addr !== 32'h44) $display("FAIL incr1_addr got=%0h exp=44", mem_addr); else pass_cnt++;
        next_cycle();
        bus_idle();
        @(negedge clk);
        total_cnt++; if (resp !== 1'b1) $display("FAIL incr_skip_resp got=%0h exp=1", resp); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL incr_skip_req got=%0h exp=0", mem_req); else pass_cnt++;
        next_cycle();
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b0, 32'h50);
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL err2_accept_ready got=%0h exp=1", readyOut); else pass_cnt++;
        next_cycle();
        addr_ph(HTRANS_SEQ, HBURST_SINGLE, 3'd2, 1'b0, 32'h54);
        @(negedge clk);
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL single_req got=%0h exp=1", mem_req); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h50) $display("FAIL single_addr got=%0h exp=50", mem_addr); else pass_cnt++;
        next_cycle();
        bus_idle();
        @(negedge clk);
        total_cnt++; if (resp !== 1'b1) $display("FAIL single_seq_resp got=%0h exp=1", resp); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL single_seq_req got=%0h exp=0", mem_req); else pass_cnt++;
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b1, 32'h8);
        next_cycle();
        bus_idle(); mem_ready = 1'b0;
        #2;
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL rmid_pre_req got=%0h exp=1", mem_req); else pass_cnt++;
        nReset = 1'b0;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rmid_req got=%0h exp=0", mem_req); else pass_cnt++;
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL rmid_ready got=%0h exp=1", readyOut); else pass_cnt++;
        next_cycle();
        nReset = 1'b1;
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b0, 32'h8);
        next_cycle();
        bus_idle(); mem_ready = 1'b1; mem_rData = 32'hCAFEF00D;
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL rmid_next_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (rData !== 32'hCAFEF00D) $display("FAIL rmid_next_rdata got=%0h exp=cafef00d", rData); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h8) $display("FAIL rmid_next_addr got=%0h exp=8", mem_addr); else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
    endtask

`ifdef AHB_SUB_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        addr_ph(HTRANS_NONSEQ, HBURST_SINGLE, 3'd2, 1'b0, 32'h0);
        next_cycle();
        bus_idle(); mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            req_cycles++;
            next_cycle();
        end
        total_cnt++; if (req_cycles != 16) $display("FAIL to_cycles got=%0d exp=16", req_cycles); else pass_cnt++;
        total_cnt++; if (resp !== 1'b1) $display("FAIL to_e1_resp got=%0h exp=1", resp); else pass_cnt++;
        total_cnt++; if (readyOut !== 1'b0) $display("FAIL to_e1_ready got=%0h exp=0", readyOut); else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++; if (readyOut !== 1'b1) $display("FAIL to_e2_ready got=%0h exp=1", readyOut); else pass_cnt++;
        total_cnt++; if (resp !== 1'b1) $display("FAIL to_e2_resp got=%0h exp=1", resp); else pass_cnt++;
        next_cycle();
    endtask
`endif

    initial begin
        nReset = 1'b0;
        bus_idle();
        wData = 32'h0; mem_ready = 1'b0; mem_rData = 32'h0; mem_err = 1'b0;
        test_reset();
        test_write_wait();
        test_read_byte();
        test_invalid_phase();
        test_mem_err();
        test_back_to_back_wrap();
        test_incr_single();
        test_reset_mid_access();
`ifdef AHB_SUB_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
